ram_arbiter: RTL and testbench

//  Sequences the three-phase RAM bus handshake (MAR load, then write or output-enable) and shares it

---
 rtl/ram_arbiter.sv | 177 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter driving the three-phase RAM handshake (MAR load, then write or OE).
// Optional per-phase watchdog is compiled in when RAM_ARB_TIMEOUT_EN is defined.
module ram_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TMO_CYC = 16
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic [2:0]    cb_out,
    output logic [AW-1:0] ab,
    output logic [DW-1:0] dob,
    input  logic [2:0]    cb_in,
    input  logic [DW-1:0] dib
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAR  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] CB_IDLE = 3'b000;
    localparam logic [2:0] CB_MAR  = 3'b001;
    localparam logic [2:0] CB_WR   = 3'b010;
    localparam logic [2:0] CB_OE   = 3'b100;

    state_t        state;
    logic          winner;
    logic          last;
    logic          cur_we;
    logic [DW-1:0] cur_wdata;
    logic          pick;
    logic          acc_ack;

    // Tie goes to the port that did not win last; otherwise the lone requester wins.
    assign pick    = (req0 && req1) ? ~last : ~req0;
    assign acc_ack = cur_we ? cb_in[1] : cb_in[2];

`ifdef RAM_ARB_TIMEOUT_EN
    localparam int           TW       = $clog2(TMO_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

    logic [TW-1:0] tmo_cnt;
    logic          err_q;

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // NOTE: async reset returns the bus to idle in the same cycle rst_b falls,
    // so a half-finished access is simply abandoned and must be re-issued.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            winner    <= 1'b0;
            last      <= 1'b1;
            cur_we    <= 1'b0;
            cur_wdata <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            rdata     <= '0;
            cb_out    <= CB_IDLE;
            ab        <= '0;
            dob       <= '0;
`ifdef RAM_ARB_TIMEOUT_EN
            tmo_cnt   <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking throughout so every output is a clean register
            // and branch order never changes what another branch observes.
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        winner    <= pick;
                        cur_we    <= pick ? we1 : we0;
                        cur_wdata <= pick ? wdata1 : wdata0;
                        ab        <= pick ? addr1 : addr0;
                        gnt0      <= ~pick;
                        gnt1      <= pick;
                        cb_out    <= CB_MAR;
`ifdef RAM_ARB_TIMEOUT_EN
                        tmo_cnt   <= '0;
`endif
                        state     <= MAR;
                    end
                end

                MAR: begin
                    if (cb_in[0]) begin
                        cb_out <= cur_we ? CB_WR : CB_OE;
                        if (cur_we) begin
                            dob <= cur_wdata;
                        end
`ifdef RAM_ARB_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                        state  <= ACC;
                    end
`ifdef RAM_ARB_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        cb_out <= CB_IDLE;
                        rdata  <= '0;
                        err_q  <= 1'b1;
                        done0  <= ~winner;
                        done1  <= winner;
                        state  <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end

                ACC: begin
                    if (acc_ack) begin
                        cb_out <= CB_IDLE;
                        if (!cur_we) begin
                            rdata <= dib;
                        end
                        done0  <= ~winner;
                        done1  <= winner;
                        state  <= DONE;
                    end
`ifdef RAM_ARB_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        cb_out <= CB_IDLE;
                        rdata  <= '0;
                        err_q  <= 1'b1;
                        done0  <= ~winner;
                        done1  <= winner;
                        state  <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end

                DONE: begin
                    // Gap cycle: the RAM's registered acks drain before the next MAR phase.
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    last  <= winner;
`ifdef RAM_ARB_TIMEOUT_EN
                    err_q <= 1'b0;
`endif
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a registered-ack RAM model; define RAM_ARB_TIMEOUT_EN
// to also exercise the watchdog abort path.
module tb_ram_arbiter;

    logic        clk;
    logic        rst_b;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, done0, done1, err;
    logic [31:0] rdata;
    logic [2:0]  cb_out;
    logic [31:0] ab, dob;
    logic [2:0]  cb_in = 3'b000;
    logic [31:0] dib = 32'h0;
    logic        ack_en = 1'b1;

    logic [31:0] mem [256];

    int checks_total  = 0;
    int checks_passed = 0;
    int checks_failed = 0;
    int viol          = 0;

    ram_arbiter #(.AW(32), .DW(32), .TMO_CYC(16)) dut (
        .clk    (clk),
        .rst_b  (rst_b),
        .req0   (req0),
        .req1   (req1),
        .we0    (we0),
        .we1    (we1),
        .addr0  (addr0),
        .addr1  (addr1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .done0  (done0),
        .done1  (done1),
        .rdata  (rdata),
        .err    (err),
        .cb_out (cb_out),
        .ab     (ab),
        .dob    (dob),
        .cb_in  (cb_in),
        .dib    (dib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: each ack is the previous cycle's strobe; read data registered alongside.
    always @(posedge clk) begin
        cb_in <= ack_en ? cb_out : 3'b000;
        if (cb_out[1]) mem[ab[7:0]] <= dob;
        if (cb_out[2]) dib <= mem[ab[7:0]];
    end

    // Bus invariants sampled every cycle outside reset.
    always @(negedge clk) begin
        if (rst_b) begin
            if ((gnt0 && gnt1) || (done0 && done1) || !$onehot0(cb_out)) viol <= viol + 1;
`ifndef RAM_ARB_TIMEOUT_EN
            if (err) viol <= viol + 1;
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else begin
            checks_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        rst_b = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        repeat (2) @(negedge clk);
        check("rst_cb_out", cb_out, 3'b000);
        check("rst_gnt", {gnt1, gnt0}, 2'b00);
        check("rst_done", {done1, done0}, 2'b00);
        check("rst_rdata", rdata, 32'h0);
        check("rst_err", err, 1'b0);
        check("rst_ab_dob", {ab, dob}, 64'h0);
        rst_b = 1'b1;
        @(negedge clk);
    endtask

    // One isolated transaction, checked cycle by cycle. Called at a negedge; returns at the
    // negedge after the DONE cycle so a following call is sampled exactly 6 edges later.
    task automatic run_single(input logic port, input logic we, input logic [7:0] a,
                              input logic [31:0] wd, input logic [31:0] exp_rd);
        if (port) begin req1 = 1; we1 = we; addr1 = {24'h0, a}; wdata1 = wd; end
        else      begin req0 = 1; we0 = we; addr0 = {24'h0, a}; wdata0 = wd; end
        @(negedge clk);
        check("grant", {gnt1, gnt0}, port ? 2'b10 : 2'b01);
        check("mar_strobe", cb_out, 3'b001);
        check("ab", ab, {24'h0, a});
        check("ack_gap", cb_in, 3'b000);
        @(negedge clk);
        check("mar_hold", cb_out, 3'b001);
        @(negedge clk);
        check("acc_strobe", cb_out, we ? 3'b010 : 3'b100);
        if (we) check("dob", dob, wd);
        @(negedge clk);
        check("no_early_done", {done1, done0}, 2'b00);
        @(negedge clk);
        check("done_pulse", {done1, done0}, port ? 2'b10 : 2'b01);
        check("done_cb_out", cb_out, 3'b000);
        check("rdata", rdata, exp_rd);
        check("err_clear", err, 1'b0);
        req0 = 0; req1 = 0;
        @(negedge clk);
        check("done_gnt_drop", {gnt1, gnt0, done1, done0}, 4'b0000);
    endtask

    initial begin
        int n;
        mem[8'h05] <= 32'hDEADBEEF;
        mem[8'hFF] <= 32'hA5A5_5A5A;
        mem[8'h00] <= 32'h0BAD_F00D;
        mem[8'h10] <= 32'h0;

        // 1: single read on port 0
        apply_reset();
        run_single(1'b0, 1'b0, 8'h05, 32'h0, 32'hDEADBEEF);

        // 2: write on port 1 leaves rdata alone, then read it back
        run_single(1'b1, 1'b1, 8'h10, 32'h12345678, 32'hDEADBEEF);
        check("mem_written", mem[8'h10], 32'h12345678);
        run_single(1'b1, 1'b0, 8'h10, 32'h0, 32'h12345678);

        // 5: back-to-back reads on port 1
        run_single(1'b1, 1'b0, 8'hFF, 32'h0, 32'hA5A5_5A5A);
        run_single(1'b1, 1'b0, 8'h00, 32'h0, 32'h0BAD_F00D);

        // 3: both ports requesting from reset alternate 0,1,0,1
        apply_reset();
        req0 = 1; we0 = 0; addr0 = 32'h05;
        req1 = 1; we1 = 0; addr1 = 32'h10;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!(done0 || done1) && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("rr_done_seen", (done0 || done1), 1'b1);
            check("rr_order", {done1, done0}, (i % 2) ? 2'b10 : 2'b01);
            check("rr_rdata", rdata, (i % 2) ? 32'h12345678 : 32'hDEADBEEF);
            if (i == 3) begin req0 = 0; req1 = 0; end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check("rr_idle", {gnt1, gnt0, cb_out}, 5'b00000);

        // 4: reset during the access phase aborts immediately
        req0 = 1; we0 = 0; addr0 = 32'h05;
        repeat (3) @(negedge clk);
        check("pre_rst_acc", cb_out, 3'b100);
        #2 rst_b = 1'b0;
        #1;
        check("rst_mid_cb_out", cb_out, 3'b000);
        check("rst_mid_gnt", {gnt1, gnt0}, 2'b00);
        check("rst_mid_rdata", rdata, 32'h0);
        req0 = 0;
        @(negedge clk);
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        run_single(1'b0, 1'b0, 8'h05, 32'h0, 32'hDEADBEEF);

`ifdef RAM_ARB_TIMEOUT_EN
        // 6: RAM never acks the MAR strobe
        ack_en = 1'b0;
        @(negedge clk);
        req0 = 1; we0 = 0; addr0 = 32'h05;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done0 && n < 40);
        check("tmo_cycles", n, 17);
        check("tmo_err", err, 1'b1);
        check("tmo_rdata", rdata, 32'h0);
        check("tmo_cb_out", cb_out, 3'b000);
        req0 = 0;
        @(negedge clk);
        check("tmo_err_clear", {err, done0, gnt0}, 3'b000);
        ack_en = 1'b1;
        repeat (2) @(negedge clk);
`endif

        check("bus_invariants", viol, 0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
